stream_split_64: RTL and testbench
==================================

Name: stream_split_64

Overview:
- Upstream feeder for the processor's 64-bit result FIFO pair.
- Accepts one 64-bit sample per handshake from the processing core.
- Splits each sample into two 32-bit Avalon-ST words: upper half to the fifo*_64_bit_up_in port, lower half to the fifo*_64_bit_down_in port.
- Counts forwarded samples and raises finalizacion once a programmed count has fully drained.

Parameters:
- DATA_W, 64, input sample width; must be even, each half is DATA_W/2.
- CNT_W, 32, width of sample counter and n_samples.

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run enable, driven from enable_export
- reset_op  in  1  synchronous operation clear, driven from reset_op_export
- n_samples  in  CNT_W  samples to forward; 0 = unlimited
- in_valid  in  1  input sample valid
- in_data  in  DATA_W  input sample
- in_ready  out  1  input ready
- up_valid  out  1  upper-word valid
- up_data  out  DATA_W/2  in_data[DATA_W-1:DATA_W/2]
- up_ready  in  1  upper-word FIFO ready
- down_valid  out  1  lower-word valid
- down_data  out  DATA_W/2  in_data[DATA_W/2-1:0]
- down_ready  in  1  lower-word FIFO ready
- sample_count  out  CNT_W  samples accepted since last clear
- finalizacion  out  1  run complete, to finalizacion_export
- stall_count  out  32  see Optional Feature

Behaviour:
- Reset (async): state=IDLE; all outputs 0 (in_ready, up_valid, down_valid, data, sample_count, finalizacion, stall_count).
- States:
  - IDLE: in_ready=0. Go to RUN when enable=1 and reset_op=0.
  - RUN: in_ready = enable & up_free & down_free, where slot_free = !slot_valid | slot_ready.
    - On accept (in_valid & in_ready): both slots load on the same edge, each valid=1; sample_count+1.
    - If n_samples!=0 and the incremented count equals n_samples, go to DRAIN.
  - DRAIN: in_ready=0. Go to DONE when up_valid=0 and down_valid=0.
  - DONE: finalizacion=1, in_ready=0. Holds until reset_op.
- Output slots:
  - Each slot holds valid and data stable until its own ready is sampled high; then valid clears unless reloaded that cycle.
  - up and down drain independently; a new sample is accepted only when both slots are free.
- Latency: accept edge to up_valid/down_valid high is 1 cycle. Sustained throughput 1 sample/cycle when both readies are held high.
- enable=0 in RUN: pause. in_ready=0, slots keep draining, state stays RUN. Resuming enable continues the count.
- n_samples is sampled live. If it is lowered below sample_count during RUN, the run never terminates; it is software's duty to set it before enable.
- n_samples=0: never leaves RUN; sample_count wraps 2^CNT_W-1 -> 0.
- reset_op=1, any state, highest priority: next edge gives state=IDLE, slots invalidated (pending words discarded), sample_count=0, finalizacion=0, stall_count=0.
- in_valid=1 while in_ready=0: no state change, no counting.

Optional Feature:
- Macro: STREAM_SPLIT_STALL_CNT_EN.
- Defined: stall_count increments each cycle with state=RUN, enable=1, in_valid=1, in_ready=0. It saturates at 0xFFFFFFFF and clears on reset or reset_op.
- Not defined: stall_count tied to 0 and no counter logic is synthesised.

Test Plan:
- n_samples=4, enable=1, both readies high, in_data=0x11112222_33334444 then +1 per cycle:
  - up_data=0x11112222 and down_data=0x33334444 are valid 1 cycle after the first accept.
  - sample_count reaches 4; finalizacion=1 on the cycle after the last words drain.
- up_ready=0 for 5 cycles with down_ready=1, continuous in_valid:
  - down word 0 drains; in_ready stays 0 until up_ready returns.
  - No sample is lost or duplicated; the scoreboard matches all pairs.
- n_samples=0, 300 samples streamed:
  - sample_count=300 and finalizacion=0 throughout.
  - Forcing the counter to 0xFFFFFFFF and accepting one more sample wraps it to 0.
- enable dropped after sample 2 of 6 for 10 cycles, then restored:
  - in_ready=0 during the pause and the pending words drain.
  - Run finishes with sample_count=6 and finalizacion=1.
- reset_op pulsed while up_valid=1 mid-run:
  - Next cycle: up_valid=0, down_valid=0, sample_count=0, state IDLE.
  - Re-enable starts counting from 1.
- Async reset asserted between clock edges:
  - All outputs are 0 immediately, without waiting for a clock edge.
- With STREAM_SPLIT_STALL_CNT_EN, in_valid=1 and down_ready=0 for 7 cycles after one accept:
  - stall_count=7.

Source files
------------

// File: rtl/stream_split_64.sv
// stream_split_64
// Upstream feeder for the 64-bit result FIFO pair. Each accepted DATA_W-bit
// sample is split into two DATA_W/2-bit Avalon-ST words: the upper half goes
// to the "up" FIFO port and the lower half to the "down" FIFO port. Accepted
// samples are counted; once n_samples (non-zero) have been accepted and both
// output words have drained, finalizacion is raised until reset_op.
//
// Optional feature macro: STREAM_SPLIT_STALL_CNT_EN
//   defined   : stall_count counts RUN cycles where a valid sample is refused
//               (enable=1, in_valid=1, in_ready=0); saturating, cleared by
//               reset / reset_op.
//   undefined : stall_count is tied to zero.
//
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   enable            : run enable (pauses acceptance when low)
//   reset_op          : synchronous operation clear, highest priority
//   n_samples         : samples to forward, 0 = unlimited
//   in_valid/in_data/in_ready       : input sample handshake
//   up_valid/up_data/up_ready       : upper-half output word
//   down_valid/down_data/down_ready : lower-half output word
//   sample_count      : samples accepted since last clear
//   finalizacion      : run complete
//   stall_count       : refused-sample cycle counter (optional feature)
module stream_split_64 #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                reset_op,
  input  logic [CNT_W-1:0]    n_samples,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                up_valid,
  output logic [DATA_W/2-1:0] up_data,
  input  logic                up_ready,
  output logic                down_valid,
  output logic [DATA_W/2-1:0] down_data,
  input  logic                down_ready,
  output logic [CNT_W-1:0]    sample_count,
  output logic                finalizacion,
  output logic [31:0]         stall_count
);

  localparam int unsigned HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                up_valid_q, up_valid_d;
  logic [HALF_W-1:0]   up_data_q, up_data_d;
  logic                down_valid_q, down_valid_d;
  logic [HALF_W-1:0]   down_data_q, down_data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    count_inc;
  logic                fin_q, fin_d;

  logic                up_free;
  logic                down_free;
  logic                ready;
  logic                accept;

  // A slot can take a new word if empty or if its word leaves this cycle.
  assign up_free   = !up_valid_q || up_ready;
  assign down_free = !down_valid_q || down_ready;
  assign ready     = (state_q == S_RUN) && enable && up_free && down_free;
  assign accept    = in_valid && ready;
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    up_valid_d   = up_valid_q && !up_ready;
    down_valid_d = down_valid_q && !down_ready;
    up_data_d    = up_data_q;
    down_data_d  = down_data_q;
    count_d      = count_q;
    fin_d        = fin_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          up_valid_d   = 1'b1;
          down_valid_d = 1'b1;
          up_data_d    = in_data[DATA_W-1:HALF_W];
          down_data_d  = in_data[HALF_W-1:0];
          count_d      = count_inc;
          if ((n_samples != '0) && (count_inc == n_samples)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!up_valid_q && !down_valid_q) begin
          state_d = S_DONE;
          fin_d   = 1'b1;
        end
      end
      S_DONE: begin
        fin_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Operation clear overrides everything, including an accept this cycle.
    if (reset_op) begin
      state_d      = S_IDLE;
      up_valid_d   = 1'b0;
      down_valid_d = 1'b0;
      count_d      = '0;
      fin_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      up_valid_q   <= 1'b0;
      up_data_q    <= '0;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      count_q      <= '0;
      fin_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      up_valid_q   <= up_valid_d;
      up_data_q    <= up_data_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      count_q      <= count_d;
      fin_q        <= fin_d;
    end
  end

`ifdef STREAM_SPLIT_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (reset_op) begin
      stall_d = '0;
    end else if ((state_q == S_RUN) && enable && in_valid && !ready &&
                 (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

  assign in_ready     = ready;
  assign up_valid     = up_valid_q;
  assign up_data      = up_data_q;
  assign down_valid   = down_valid_q;
  assign down_data    = down_data_q;
  assign sample_count = count_q;
  assign finalizacion = fin_q;

endmodule

// File: tb/tb_stream_split_64.sv
module tb_stream_split_64;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        reset_op;
  logic [31:0] n_samples;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        up_valid;
  logic [31:0] up_data;
  logic        up_ready;
  logic        down_valid;
  logic [31:0] down_data;
  logic        down_ready;
  logic [31:0] sample_count;
  logic        finalizacion;
  logic [31:0] stall_count;

  // Narrow-counter instance used to exercise counter wrap in reasonable time.
  logic        w8_in_ready;
  logic        w8_up_valid;
  logic [31:0] w8_up_data;
  logic        w8_down_valid;
  logic [31:0] w8_down_data;
  logic [7:0]  w8_count;
  logic        w8_fin;
  logic [31:0] w8_stall;

  always #5 clk = ~clk;

  stream_split_64 #(.DATA_W(64), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .reset_op(reset_op),
    .n_samples(n_samples), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .up_valid(up_valid), .up_data(up_data),
    .up_ready(up_ready), .down_valid(down_valid), .down_data(down_data),
    .down_ready(down_ready), .sample_count(sample_count),
    .finalizacion(finalizacion), .stall_count(stall_count)
  );

  stream_split_64 #(.DATA_W(64), .CNT_W(8)) u_dut_w8 (
    .clk(clk), .reset(reset), .enable(1'b1), .reset_op(1'b0),
    .n_samples(8'd0), .in_valid(1'b1), .in_data(64'hA5A5_0000_5A5A_FFFF),
    .in_ready(w8_in_ready), .up_valid(w8_up_valid), .up_data(w8_up_data),
    .up_ready(1'b1), .down_valid(w8_down_valid), .down_data(w8_down_data),
    .down_ready(1'b1), .sample_count(w8_count),
    .finalizacion(w8_fin), .stall_count(w8_stall)
  );

  // Transaction-level reference model
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_t;
  mphase_t     m_ph;
  logic [31:0] eu[$];
  logic [31:0] ed[$];
  logic [31:0] m_count;
  logic        m_fin;
  logic [31:0] m_stall;
  logic        w8_run;
  logic [7:0]  w8_m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ph    = M_IDLE;
    eu      = {};
    ed      = {};
    m_count = '0;
    m_fin   = 1'b0;
    m_stall = '0;
  endtask

  task automatic model_reset();
    model_clear();
    w8_run = 1'b0;
    w8_m   = '0;
  endtask

  // One clock: compare at the falling edge, advance the model across the
  // rising edge, return 1 time unit after it.
  task automatic tick();
    logic m_ready;
    logic up_emp, dn_emp;
    @(negedge clk);
    up_emp  = (eu.size() == 0);
    dn_emp  = (ed.size() == 0);
    m_ready = (m_ph == M_RUN) && enable && (up_emp || up_ready) && (dn_emp || down_ready);
    chk("in_ready", in_ready, m_ready);
    chk("up_valid", up_valid, !up_emp);
    chk("down_valid", down_valid, !dn_emp);
    chk("sample_count", sample_count, m_count);
    chk("finalizacion", finalizacion, m_fin);
`ifdef STREAM_SPLIT_STALL_CNT_EN
    chk("stall_count", stall_count, m_stall);
`else
    chk("stall_count", stall_count, 0);
`endif
    chk("w8_in_ready", w8_in_ready, w8_run);
    chk("w8_count", w8_count, w8_m);

    if (reset) begin
      model_reset();
    end else begin
      if (w8_run) w8_m = w8_m + 8'd1;
      else        w8_run = 1'b1;
      if (reset_op) begin
        model_clear();
      end else begin
        if (!up_emp && up_ready) begin
          chk("up_data", up_data, eu[0]);
          void'(eu.pop_front());
        end
        if (!dn_emp && down_ready) begin
          chk("down_data", down_data, ed[0]);
          void'(ed.pop_front());
        end
        case (m_ph)
          M_IDLE: if (enable) m_ph = M_RUN;
          M_RUN: begin
            if (enable && in_valid && !m_ready && m_stall != 32'hFFFF_FFFF)
              m_stall = m_stall + 1;
            if (in_valid && m_ready) begin
              eu.push_back(in_data[63:32]);
              ed.push_back(in_data[31:0]);
              m_count = m_count + 1;
              if (n_samples != 0 && m_count == n_samples) m_ph = M_DRAIN;
            end
          end
          M_DRAIN: if (up_emp && dn_emp) begin m_ph = M_DONE; m_fin = 1'b1; end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit first_seen;
    reset = 1'b1; enable = 1'b0; reset_op = 1'b0; n_samples = '0;
    in_valid = 1'b0; in_data = '0; up_ready = 1'b1; down_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_up_valid", up_valid, 0);
    chk("rst_count", sample_count, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Scenario 1: n=4, readies high, incrementing data
    n_samples = 4; enable = 1'b1; in_valid = 1'b1;
    first_seen = 1'b0;
    for (int i = 0; i < 30 && !m_fin; i++) begin
      in_data = 64'h1111_2222_3333_4444 + 64'(m_count);
      tick();
      if (m_count == 1 && !first_seen) begin
        first_seen = 1'b1;
        chk("first_up_data", up_data, 32'h1111_2222);
        chk("first_down_data", down_data, 32'h3333_4444);
      end
    end
    chk("s1_fin", finalizacion, 1);
    chk("s1_count", sample_count, 4);
    for (int i = 0; i < 3; i++) tick();

    // Scenario 2: up_ready low for 5 cycles
    reset_op = 1'b1; tick(); reset_op = 1'b0;
    n_samples = 0;
    for (int i = 0; i < 4; i++) begin in_data = {$urandom(), $urandom()}; tick(); end
    up_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin in_data = {$urandom(), $urandom()}; tick(); end
    chk("s2_stalled", in_ready, 0);
    up_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin in_data = {$urandom(), $urandom()}; tick(); end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Scenario 3: unlimited run, 300 samples with random readies
    reset_op = 1'b1; tick(); reset_op = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2000 && m_count != 300; i++) begin
      in_data    = {$urandom(), $urandom()};
      up_ready   = ($urandom_range(0, 3) != 0);
      down_ready = ($urandom_range(0, 3) != 0);
      if (m_count == 299) begin up_ready = 1'b1; down_ready = 1'b1; end
      tick();
    end
    in_valid = 1'b0; up_ready = 1'b1; down_ready = 1'b1;
    tick(); tick();
    chk("s3_count", sample_count, 300);
    chk("s3_fin", finalizacion, 0);

    // Scenario 4: pause after sample 2 of 6
    reset_op = 1'b1; tick(); reset_op = 1'b0;
    n_samples = 6; in_valid = 1'b1;
    for (int i = 0; i < 20 && m_count != 2; i++) begin in_data = {$urandom(), $urandom()}; tick(); end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin in_data = {$urandom(), $urandom()}; tick(); end
    chk("s4_pause_ready", in_ready, 0);
    chk("s4_pause_drained", up_valid, 0);
    enable = 1'b1;
    for (int i = 0; i < 30 && !m_fin; i++) begin in_data = {$urandom(), $urandom()}; tick(); end
    chk("s4_count", sample_count, 6);
    chk("s4_fin", finalizacion, 1);

    // Scenario 5: reset_op while up word pending
    reset_op = 1'b1; tick(); reset_op = 1'b0;
    n_samples = 0; up_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin in_data = {$urandom(), $urandom()}; tick(); end
    chk("s5_up_pending", up_valid, 1);
    reset_op = 1'b1; tick(); reset_op = 1'b0;
    chk("s5_up_valid", up_valid, 0);
    chk("s5_down_valid", down_valid, 0);
    chk("s5_count", sample_count, 0);
    up_ready = 1'b1;
    tick();
    in_data = {$urandom(), $urandom()}; tick();
    chk("s5_restart_count", sample_count, 1);

    // Scenario 6: stall counter, down_ready low after one accept
    reset_op = 1'b1; tick(); reset_op = 1'b0;
    for (int i = 0; i < 10 && m_count != 1; i++) begin in_data = {$urandom(), $urandom()}; tick(); end
    down_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
`ifdef STREAM_SPLIT_STALL_CNT_EN
    chk("s6_stall", stall_count, 7);
`else
    chk("s6_stall", stall_count, 0);
`endif
    down_ready = 1'b1;
    tick();

    // Scenario 7: async reset between edges with words pending
    up_ready = 1'b0;
    in_data = {$urandom(), $urandom()}; tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_in_ready", in_ready, 0);
    chk("ar_up_valid", up_valid, 0);
    chk("ar_down_valid", down_valid, 0);
    chk("ar_up_data", up_data, 0);
    chk("ar_down_data", down_data, 0);
    chk("ar_count", sample_count, 0);
    chk("ar_fin", finalizacion, 0);
    chk("ar_stall", stall_count, 0);
    chk("ar_w8_count", w8_count, 0);
    model_reset();
    tick();
    reset = 1'b0; up_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin in_data = {$urandom(), $urandom()}; tick(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
